bias_ctrl: RTL and testbench

Sequencer for the row of per-column bias units between the systolic array and activation stage. On `start` it fetches one 16-bit bias per column from the unified buffer, broadcasts them to the bias units with a single `load_bias` strobe, then gates and counts the array's per-column valid stream until every column has emitted `cfg_rows` results. Completion is reported with a `done` pulse.

---
 rtl/bias_ctrl_pkg.sv | 7 +
 rtl/bias_col_counter.sv | 29 ++
 rtl/bias_ctrl.sv | 103 ++++++++++
 tb/tb_bias_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/bias_ctrl_pkg.sv
// bias_ctrl_pkg: shared FSM state type and default widths for the bias sequencer
package bias_ctrl_pkg;
  localparam int BC_DATA_W = 16;
  localparam int BC_ADDR_W = 16;
  localparam int BC_ROW_W = 8;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_RUN, S_DONE} bias_ctrl_state_t;
endpackage

// File: rtl/bias_col_counter.sv
// bias_col_counter: per-column valid gate, saturating row counter (clr/en_run/rows/valid_in -> valid_out/col_done_nxt/err)
module bias_col_counter #(
  parameter int ROW_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en_run,
  input  logic [ROW_W-1:0] rows,
  input  logic             valid_in,
  output logic             valid_out,
  output logic             col_done_nxt,
  output logic             err
);
  logic [ROW_W-1:0] cnt;
  logic col_done;
  assign valid_out = valid_in & en_run & ~col_done;
  assign col_done_nxt = col_done | (valid_out && cnt + ROW_W'(1) == rows);
  assign err = valid_in & ~valid_out;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      col_done <= 1'b0;
    end else begin
      if (valid_out) cnt <= cnt + ROW_W'(1);
      col_done <= col_done_nxt;
    end
  end
endmodule

// File: rtl/bias_ctrl.sv
// bias_ctrl: fetches per-column biases from the unified buffer, strobes them into bias units, gates/counts array valids, pulses done
module bias_ctrl import bias_ctrl_pkg::*; #(
  parameter int NUM_COLS = 2,
  parameter int DATA_W = BC_DATA_W,
  parameter int ADDR_W = BC_ADDR_W,
  parameter int ROW_W = BC_ROW_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          cfg_bias_base,
  input  logic [ROW_W-1:0]           cfg_rows,
  output logic                       ub_rd_en,
  output logic [ADDR_W-1:0]          ub_rd_addr,
  input  logic [DATA_W-1:0]          ub_rd_data,
  input  logic [NUM_COLS-1:0]        array_valid_in,
  output logic [NUM_COLS-1:0]        bias_load_out,
  output logic [NUM_COLS*DATA_W-1:0] bias_data_out,
  output logic [NUM_COLS-1:0]        bias_valid_out,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);
  localparam int IW = NUM_COLS > 1 ? $clog2(NUM_COLS) : 1;
  bias_ctrl_state_t state;
  logic [IW-1:0] idx, rd_idx;
  logic rd_v;
  logic [ROW_W-1:0] rows;
  logic [NUM_COLS-1:0] col_done_nxt, col_err;
  logic clr, en_run;
  assign clr = state == S_IDLE && start;
  assign en_run = state == S_RUN;
  for (genvar g = 0; g < NUM_COLS; g++) begin : g_col
    bias_col_counter #(.ROW_W(ROW_W)) u_cnt (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .en_run(en_run),
      .rows(rows),
      .valid_in(array_valid_in[g]),
      .valid_out(bias_valid_out[g]),
      .col_done_nxt(col_done_nxt[g]),
      .err(col_err[g])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ub_rd_en <= 1'b0;
      ub_rd_addr <= '0;
      idx <= '0;
      rd_idx <= '0;
      rd_v <= 1'b0;
      rows <= '0;
      bias_load_out <= '0;
      bias_data_out <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      rd_v <= ub_rd_en;
      rd_idx <= idx;
      for (int c = 0; c < NUM_COLS; c++)
        if (rd_v && rd_idx == IW'(c)) bias_data_out[c*DATA_W +: DATA_W] <= ub_rd_data;
      err <= clr ? 1'b0 : err | (|col_err);
      bias_load_out <= '0;
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state <= S_FETCH;
          rows <= cfg_rows;
          ub_rd_addr <= cfg_bias_base;
          idx <= '0;
          ub_rd_en <= 1'b1;
          busy <= 1'b1;
        end
        S_FETCH: if (ub_rd_en) begin
          if (idx == IW'(NUM_COLS - 1)) ub_rd_en <= 1'b0;
          else begin
            idx <= idx + IW'(1);
            ub_rd_addr <= ub_rd_addr + ADDR_W'(1);
          end
        end else begin
          state <= S_LOAD;
          bias_load_out <= '1;
        end
        S_LOAD: begin
          state <= rows == '0 ? S_DONE : S_RUN;
          done <= rows == '0;
        end
        S_RUN: if (&col_done_nxt) begin
          state <= S_DONE;
          done <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bias_ctrl.sv
// tb_bias_ctrl: table-driven, hand-written and randomized checks of bias_ctrl against a timeline model
module tb_bias_ctrl;
  localparam int N = 2;
  logic clk = 0, rst = 1, start = 0;
  logic [15:0] cfg_bias_base = 0;
  logic [7:0] cfg_rows = 0;
  logic ub_rd_en;
  logic [15:0] ub_rd_addr;
  logic [15:0] ub_rd_data = 0;
  logic [1:0] array_valid_in = 0;
  logic [1:0] bias_load_out, bias_valid_out;
  logic [31:0] bias_data_out;
  logic busy, done, err;
  bias_ctrl #(.NUM_COLS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_bias_base(cfg_bias_base), .cfg_rows(cfg_rows),
    .ub_rd_en(ub_rd_en), .ub_rd_addr(ub_rd_addr), .ub_rd_data(ub_rd_data),
    .array_valid_in(array_valid_in), .bias_load_out(bias_load_out), .bias_data_out(bias_data_out),
    .bias_valid_out(bias_valid_out), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  logic [15:0] mem [65536];
  always @(posedge clk) if (ub_rd_en) ub_rd_data <= mem[ub_rd_addr];
  int total = 0, bad = 0;
  bit m_act = 0, m_err = 0;
  int m_t = 0, m_done_t = -1, m_rows = 0, done_seen = -1;
  int m_cnt [2] = '{0, 0};
  logic [15:0] m_base = 0;
  logic [15:0] m_data [2] = '{16'h0, 16'h0};
  typedef struct {
    logic [15:0] base;
    int rows, f0, f1, over0, stray_k, start_k, exp_done;
    logic exp_err;
    logic [31:0] exp_data;
  } job_t;
  job_t tbl [8];
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0d, %0t)", nm, a, e, m_t, $time);
    end
  endtask
  function automatic bit in_run();
    return m_act && m_t >= N + 3 && (m_done_t < 0 || m_t < m_done_t);
  endfunction
  task automatic cyc();
    logic [1:0] ev;
    logic [15:0] ea;
    bit nerr, run;
    @(negedge clk);
    run = in_run();
    for (int c = 0; c < 2; c++) ev[c] = run && array_valid_in[c] && m_cnt[c] < m_rows;
    chk("rd_en", ub_rd_en, m_act && m_t >= 1 && m_t <= N);
    ea = m_base + 16'(m_t - 1);
    if (m_act && m_t >= 1 && m_t <= N) chk("rd_addr", ub_rd_addr, ea);
    chk("load", bias_load_out, (m_act && m_t == N + 2) ? 2'b11 : 2'b00);
    chk("data", bias_data_out, {m_data[1], m_data[0]});
    chk("valid_out", bias_valid_out, ev);
    chk("busy", busy, m_act);
    chk("done", done, m_act && m_t == m_done_t);
    chk("err", err, m_err);
    if (done === 1'b1) done_seen = m_t;
    @(posedge clk);
    if (rst) begin
      m_act = 0; m_err = 0; m_done_t = -1; m_t = 0;
      m_cnt = '{0, 0}; m_data = '{16'h0, 16'h0};
    end else begin
      nerr = m_err;
      for (int c = 0; c < 2; c++) if (array_valid_in[c] && !ev[c]) nerr = 1;
      if (m_act) begin
        ea = m_base + 16'(m_t - 2);
        if (m_t >= 2 && m_t <= N + 1) m_data[m_t-2] = mem[ea];
        for (int c = 0; c < 2; c++) if (ev[c]) m_cnt[c]++;
        if (run && m_cnt[0] == m_rows && m_cnt[1] == m_rows) m_done_t = m_t + 1;
        if (m_t == m_done_t) m_act = 0; else m_t++;
      end else if (start) begin
        m_act = 1; m_t = 1; m_base = cfg_bias_base; m_rows = cfg_rows;
        m_cnt = '{0, 0}; nerr = 0;
        m_done_t = cfg_rows == 0 ? N + 3 : -1;
      end
      m_err = nerr;
    end
    #1;
  endtask
  task automatic run_job(input job_t e);
    cfg_bias_base = e.base; cfg_rows = 8'(e.rows); start = 1; done_seen = -1;
    cyc();
    start = 0;
    for (int k = 1; k < 60 && done_seen < 0; k++) begin
      array_valid_in[0] = k >= e.f0 && k < e.f0 + e.rows + e.over0;
      array_valid_in[1] = k >= e.f1 && k < e.f1 + e.rows;
      if (k == e.stray_k) array_valid_in = 2'b11;
      start = k == e.start_k;
      cyc();
    end
    array_valid_in = 0; start = 0;
    cyc();
    chk("job_done_cycle", done_seen, e.exp_done);
    chk("job_err", err, e.exp_err);
    chk("job_bias_data", bias_data_out, e.exp_data);
  endtask
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 40503) ^ 16'h5a5a;
    mem[16'h0040] = 16'h0180; mem[16'h0041] = 16'hFF00;
    mem[16'h0100] = 16'h1234; mem[16'h0101] = 16'hABCD;
    mem[16'hFFFF] = 16'h7FFF; mem[16'h0000] = 16'h8001;
    mem[16'h0200] = 16'h0011; mem[16'h0201] = 16'h0022;
    //            base      rows f0 f1 ov st sk done err data
    tbl[0] = '{16'h0040, 3, 5, 6, 0, 0, 0, 9, 1'b0, 32'hFF00_0180};
    tbl[1] = '{16'h0100, 0, 0, 0, 0, 0, 0, 5, 1'b0, 32'hABCD_1234};
    tbl[2] = '{16'h0040, 3, 5, 5, 1, 0, 0, 8, 1'b1, 32'hFF00_0180};
    tbl[3] = '{16'hFFFF, 2, 5, 5, 0, 0, 0, 7, 1'b0, 32'h8001_7FFF};
    tbl[4] = '{16'h0200, 1, 7, 5, 0, 0, 0, 8, 1'b0, 32'h0022_0011};
    tbl[5] = '{16'h0100, 2, 5, 5, 0, 1, 0, 7, 1'b1, 32'hABCD_1234};
    tbl[6] = '{16'h0200, 3, 5, 5, 0, 0, 6, 8, 1'b0, 32'h0022_0011};
    tbl[7] = '{16'h0200, 1, 5, 5, 0, 0, 6, 6, 1'b0, 32'h0022_0011};
    repeat (2) @(posedge clk);
    #1;
    cyc();
    rst = 0;
    cyc();
    array_valid_in = 2'b01;
    cyc();
    array_valid_in = 0;
    cyc();
    chk("stray_idle_err", err, 1'b1);
    for (int i = 0; i < 8; i++) run_job(tbl[i]);
    cfg_bias_base = 16'h0040; cfg_rows = 3; start = 1; done_seen = -1;
    cyc();
    start = 0;
    for (int k = 1; k <= 5; k++) begin
      array_valid_in = k == 5 ? 2'b11 : 2'b00;
      cyc();
    end
    array_valid_in = 0; rst = 1;
    cyc();
    rst = 0;
    cyc();
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", bias_data_out, 32'h0);
    chk("rst_err", err, 1'b0);
    repeat (6) cyc();
    chk("rst_no_done", done_seen, -1);
    run_job(tbl[0]);
    for (int j = 0; j < 25; j++) begin
      cfg_bias_base = 16'($urandom); cfg_rows = 8'($urandom_range(0, 4)); start = 1; done_seen = -1;
      cyc();
      start = 0;
      for (int k = 1; k < 80 && done_seen < 0; k++) begin
        array_valid_in = k >= 5 ? 2'($urandom) : ($urandom % 8 == 0 ? 2'($urandom) : 2'b00);
        start = $urandom % 10 == 0;
        cyc();
      end
      array_valid_in = 0; start = 0;
      cyc();
      chk("rand_job_finished", done_seen >= 0, 1'b1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
